// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the fetch stage.
//
// Selects the next PC from the redirect sources, in priority order, highest first:
//   exception entry, exception return, stall, return, jump-register, jump,
//   taken branch, and finally sequential pc+4.
// A 'call' on a winning jump or jr pushes pc+4 onto a small circular
// return-address stack (RAS). On overflow the oldest entry is overwritten.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   Defined   : a misaligned ret/jr/jump/branch target traps to EXC_VECTOR,
//               epc takes the faulting target, and misaligned pulses for one cycle.
//   Undefined : next-PC bits [1:0] are forced to zero and misaligned is tied to 0.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall             hold PC (exc/eret still act)
//   branch_taken      pc <= pc + branch_offset
//   branch_offset     signed byte offset
//   jump/jump_target  absolute jump
//   jr/jr_target      jump to register; jr_target is also the fallback when ret
//                     finds an empty RAS
//   call              push pc+4 alongside a winning jump or jr
//   ret               pop the RAS into pc
//   exc, eret         exception entry / return
//   pc, pc_plus4      current PC and its sequential successor
//   epc               saved exception PC
//   ras_empty/full    RAS occupancy flags
//   misaligned        registered alignment-fault pulse
module pc_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned EXC_VECTOR   = 32'h0000_0180,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misaligned
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    // wr_ptr points at the slot the next push writes; the top entry sits just below it.
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    top_ptr;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] next_epc;
    logic [WIDTH-1:0] target;
    logic             push;
    logic             pop;

    assign pc_plus4  = pc + WIDTH'(4);
    assign top_ptr   = wr_ptr - PW'(1);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(RAS_DEPTH));

`ifdef PC_ALIGN_CHECK_EN
    logic next_mis;
    logic mis_q;
    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        next_pc  = pc_plus4;
        next_epc = epc;
        target   = pc_plus4;
        push     = 1'b0;
        pop      = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        next_mis = 1'b0;
`endif
        if (exc) begin
            next_pc  = EXC_PC;
            next_epc = pc;
        end else if (eret) begin
            next_pc = epc;
        end else if (stall) begin
            next_pc = pc;
        end else begin
            if (ret) begin
                if (!ras_empty) begin
                    target = ras_mem[top_ptr];
                    pop    = 1'b1;
                end else begin
                    target = jr_target;
                end
            end else if (jr) begin
                target = jr_target;
                push   = call;
            end else if (jump) begin
                target = jump_target;
                push   = call;
            end else if (branch_taken) begin
                target = pc + branch_offset;
            end
            next_pc = target;
`ifdef PC_ALIGN_CHECK_EN
            // A misaligned redirect traps instead; the call push is dropped.
            if ((ret || jr || jump || branch_taken) && (target[1:0] != 2'b00)) begin
                next_pc  = EXC_PC;
                next_epc = target;
                next_mis = 1'b1;
                push     = 1'b0;
            end
`endif
        end
`ifndef PC_ALIGN_CHECK_EN
        next_pc[1:0] = 2'b00;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RST_PC;
            epc    <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            pc  <= next_pc;
            epc <= next_epc;
            if (pop) begin
                wr_ptr <= top_ptr;
                count  <= count - CW'(1);
            end else if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                // Count saturates; a full stack overwrites its oldest entry.
                if (!ras_full) begin
                    count <= count + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_mem[wr_ptr] <= pc_plus4;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= next_mis;
        end
    end
`endif

endmodule
